// File: rtl/xoro_stream.sv
// xoroshiro128+ generator feeding a small prefetch FIFO of 32-bit words.
// Each 64-bit result is pushed low half first, then high half; reseeding goes through a shadow register.
module xoro_stream #(
  parameter int          DEPTH = 4,
  parameter logic [63:0] SEED0 = 64'h0000_0000_0000_0001,
  parameter logic [63:0] SEED1 = 64'h0000_0000_0000_0002
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seed_wr,
  input  logic [1:0]               seed_idx,
  input  logic [31:0]              seed_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    GEN_LO,
    GEN_HI,
    COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     s0_q, s0_d, s1_q, s1_d;
  logic [127:0]    shadow_q, shadow_d;
  logic [31:0]     hi_hold_q, hi_hold_d;
  logic [31:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;

  logic [63:0]     result, t, s0_next, s1_next;
  logic            push, pop, step, commit;
  logic [31:0]     push_data;

  always_comb begin
    result  = s0_q + s1_q;
    t       = s0_q ^ s1_q;
    s0_next = {s0_q[39:0], s0_q[63:40]} ^ t ^ (t << 16);
    s1_next = {t[26:0], t[63:27]};
  end

  always_comb begin
    shadow_d = shadow_q;
    if (seed_wr) begin
      case (seed_idx)
        2'd0:    shadow_d[31:0]   = seed_data;
        2'd1:    shadow_d[63:32]  = seed_data;
        2'd2:    shadow_d[95:64]  = seed_data;
        default: shadow_d[127:96] = seed_data;
      endcase
    end
  end

  // Push is gated on the registered level only; a same-cycle pop never makes room.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = hi_hold_q;
    step      = 1'b0;
    commit    = 1'b0;
    case (state_q)
      GEN_LO: begin
        if (level_q < FULL) begin
          push      = 1'b1;
          push_data = result[31:0];
          step      = 1'b1;
          state_d   = GEN_HI;
        end
      end
      GEN_HI: begin
        if (level_q < FULL) begin
          push    = 1'b1;
          state_d = GEN_LO;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = GEN_LO;
      end
      default: state_d = GEN_LO;
    endcase
    if (seed_wr && seed_idx == 2'd3) begin
      state_d = COMMIT;
    end
  end

  assign pop = out_valid && out_ready;

  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    hi_hold_d = hi_hold_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (step) begin
      s0_d      = s0_next;
      s1_d      = s1_next;
      hi_hold_d = result[63:32];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    // Flush beats any same-cycle handshake; an all-zero seed would lock the generator at zero.
    if (commit) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      if (shadow_q == '0) begin
        s0_d = SEED0;
        s1_d = SEED1;
      end else begin
        s0_d = shadow_q[63:0];
        s1_d = shadow_q[127:64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= GEN_LO;
      s0_q      <= SEED0;
      s1_q      <= SEED1;
      shadow_q  <= {SEED1, SEED0};
      hi_hold_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      shadow_q  <= shadow_d;
      hi_hold_q <= hi_hold_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: tb/tb_xoro_stream.sv
// Directed and randomised-backpressure checks of xoro_stream against hand-computed words
// and a small xoroshiro128+ reference model.
module tb_xoro_stream;

  logic        clk;
  logic        reset;
  logic        seed_wr;
  logic [1:0]  seed_idx;
  logic [31:0] seed_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  level;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] got [8];
  int          gotCyc [8];
  int          gotN;

  xoro_stream #(
    .DEPTH(4),
    .SEED0(64'h0000_0000_0000_0001),
    .SEED1(64'h0000_0000_0000_0002)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_wr   (seed_wr),
    .seed_idx  (seed_idx),
    .seed_data (seed_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic seed_write(input logic [1:0] idx, input logic [31:0] data);
    seed_wr   = 1'b1;
    seed_idx  = idx;
    seed_data = data;
    tick();
    seed_wr   = 1'b0;
  endtask

  // Records words as they are handshaken, with the cycle index of each, within a cycle budget.
  task automatic collect(input int n, input int budget);
    gotN = 0;
    for (int c = 0; c < budget && gotN < n; c++) begin
      if (out_valid && out_ready) begin
        got[gotN]    = out_data;
        gotCyc[gotN] = c;
        gotN++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    seed_wr   = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    assertCount++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
      failCount++;
    end
    assertCount++;
    if (level !== 3'd0) begin
      $display("[TB] FAIL reset_level: got %0d want 0", level);
      failCount++;
    end
    assertCount++;
    if (out_data !== 32'h0) begin
      $display("[TB] FAIL reset_data: got %h want 0", out_data);
      failCount++;
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] expW [4];
    expW[0] = 32'h0000_0003;
    expW[1] = 32'h0000_0000;
    expW[2] = 32'h0103_0003;
    expW[3] = 32'h0000_0060;
    out_ready = 1'b1;
    do_reset();
    collect(4, 20);
    assertCount++;
    if (gotN !== 4) begin
      $display("[TB] FAIL stream_count: got %0d words want 4", gotN);
      failCount++;
    end
    assertCount++;
    if (gotCyc[0] !== 1) begin
      $display("[TB] FAIL stream_first_latency: got cycle %0d want 1", gotCyc[0]);
      failCount++;
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL stream_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
    for (int i = 1; i < 4; i++) begin
      assertCount++;
      if (gotCyc[i] - gotCyc[i-1] !== 1) begin
        $display("[TB] FAIL stream_rate%0d: got gap %0d want 1", i, gotCyc[i] - gotCyc[i-1]);
        failCount++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] expW [4];
    expW[0] = 32'h0000_0003;
    expW[1] = 32'h0000_0000;
    expW[2] = 32'h0103_0003;
    expW[3] = 32'h0000_0060;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    assertCount++;
    if (level !== 3'd4) begin
      $display("[TB] FAIL full_level: got %0d want 4", level);
      failCount++;
    end
    assertCount++;
    if (out_valid !== 1'b1) begin
      $display("[TB] FAIL full_valid: got %b want 1", out_valid);
      failCount++;
    end
    assertCount++;
    if (out_data !== 32'h3) begin
      $display("[TB] FAIL full_head: got %h want 00000003", out_data);
      failCount++;
    end
    out_ready = 1'b1;
    collect(4, 20);
    assertCount++;
    if (gotN !== 4) begin
      $display("[TB] FAIL drain_count: got %0d words want 4", gotN);
      failCount++;
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL drain_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
  endtask

  task automatic test_seed();
    logic [31:0] expW [4];
    expW[0] = 32'h0000_000F;
    expW[1] = 32'h0000_0000;
    expW[2] = 32'h050F_000F;
    expW[3] = 32'h0000_01E0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    seed_write(2'd0, 32'h5);
    seed_write(2'd1, 32'h0);
    seed_write(2'd2, 32'hA);
    seed_write(2'd3, 32'h0);
    tick();
    assertCount++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      $display("[TB] FAIL seed_flush: got valid=%b level=%0d want valid=0 level=0", out_valid, level);
      failCount++;
    end
    collect(4, 20);
    assertCount++;
    if (gotN !== 4 || gotCyc[0] !== 1) begin
      $display("[TB] FAIL seed_restart: got %0d words first at cycle %0d want 4 at 1", gotN, gotCyc[0]);
      failCount++;
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL seed_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
  endtask

  task automatic test_zero_seed();
    logic [31:0] expW [4];
    expW[0] = 32'h0000_0003;
    expW[1] = 32'h0000_0000;
    expW[2] = 32'h0103_0003;
    expW[3] = 32'h0000_0060;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 4; i++) seed_write(2'(i), 32'h0);
    tick();
    collect(4, 20);
    assertCount++;
    if (gotN !== 4) begin
      $display("[TB] FAIL zero_seed_count: got %0d words want 4", gotN);
      failCount++;
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL zero_seed_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
  endtask

  task automatic test_commit_full();
    logic [31:0] expW [4];
    expW[0] = 32'h0000_000F;
    expW[1] = 32'h0000_0000;
    expW[2] = 32'h050F_000F;
    expW[3] = 32'h0000_01E0;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    seed_write(2'd0, 32'h5);
    seed_write(2'd1, 32'h0);
    seed_write(2'd2, 32'hA);
    assertCount++;
    if (level !== 3'd4) begin
      $display("[TB] FAIL commit_full_pre: got level %0d want 4", level);
      failCount++;
    end
    seed_write(2'd3, 32'h0);
    out_ready = 1'b1;
    tick();
    assertCount++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      $display("[TB] FAIL commit_full_flush: got level=%0d valid=%b want 0/0", level, out_valid);
      failCount++;
    end
    collect(4, 20);
    assertCount++;
    if (gotN !== 4) begin
      $display("[TB] FAIL commit_full_count: got %0d words want 4", gotN);
      failCount++;
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL commit_full_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] expW [4];
    expW[0] = 32'h0000_0003;
    expW[1] = 32'h0000_0000;
    expW[2] = 32'h0103_0003;
    expW[3] = 32'h0000_0060;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    // Partial seed sequence interrupted by reset: the shadow must be reloaded with the defaults.
    seed_write(2'd0, 32'h5);
    seed_write(2'd2, 32'hA);
    reset = 1'b1;
    tick();
    assertCount++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      $display("[TB] FAIL midreset_state: got valid=%b level=%0d want 0/0", out_valid, level);
      failCount++;
    end
    reset = 1'b0;
    collect(4, 20);
    assertCount++;
    if (gotN !== 4) begin
      $display("[TB] FAIL midreset_count: got %0d words want 4", gotN);
      failCount++;
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL midreset_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
    seed_write(2'd3, 32'h0);
    tick();
    collect(4, 20);
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (got[i] !== expW[i]) begin
        $display("[TB] FAIL shadow_reload_word%0d: got %h want %h", i, got[i], expW[i]);
        failCount++;
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] ms0, ms1, r, mt;
    logic [31:0] mhi, expWord, prevData;
    logic        mphase, prevHold;
    int          consumed;
    ms0      = 64'h1;
    ms1      = 64'h2;
    mhi      = '0;
    mphase   = 1'b0;
    prevHold = 1'b0;
    prevData = '0;
    consumed = 0;
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (level > 3'd4) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL rand_level: got %0d want <= 4", level);
      end
      if (prevHold) begin
        assertCount++;
        if (out_valid !== 1'b1 || out_data !== prevData) begin
          $display("[TB] FAIL rand_hold: got valid=%b data=%h want 1/%h", out_valid, out_data, prevData);
          failCount++;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (!mphase) begin
          r       = ms0 + ms1;
          mt      = ms0 ^ ms1;
          expWord = r[31:0];
          mhi     = r[63:32];
          ms0     = {ms0[39:0], ms0[63:40]} ^ mt ^ (mt << 16);
          ms1     = {mt[26:0], mt[63:27]};
        end else begin
          expWord = mhi;
        end
        mphase = ~mphase;
        consumed++;
        assertCount++;
        if (out_data !== expWord) begin
          $display("[TB] FAIL rand_word%0d: got %h want %h", consumed, out_data, expWord);
          failCount++;
        end
      end
      prevHold = out_valid && !out_ready;
      prevData = out_data;
      tick();
    end
    assertCount++;
    if (consumed < 2000) begin
      $display("[TB] FAIL rand_throughput: got %0d words want >= 2000", consumed);
      failCount++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    seed_wr   = 1'b0;
    seed_idx  = 2'd0;
    seed_data = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_seed();
    test_zero_seed();
    test_commit_full();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/xoro_stream.md
Name: xoro_stream

Overview:
- Free-running xoroshiro128+ generator with a prefetch FIFO.
- Delivers 32-bit random words to the PRNG bus interface over a valid/ready stream, so bus reads never stall on generation.
- Supports run-time reseeding through four 32-bit seed writes issued by the bus interface.
- Sits directly upstream of the PRNG bus interface.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of two, >= 2.
- SEED0, 64'h0000_0000_0000_0001, reset and fallback value of state word s0.
- SEED1, 64'h0000_0000_0000_0002, reset and fallback value of state word s1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_wr  in  1  seed word write strobe.
- seed_idx  in  2  seed word select: 0 = s0[31:0], 1 = s0[63:32], 2 = s1[31:0], 3 = s1[63:32]; a write to index 3 commits the seed.
- seed_data  in  32  seed word.
- out_valid  out  1  FIFO head word is valid.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  32  FIFO head word.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (clk edge with reset=1):
  - s0=SEED0, s1=SEED1; shadow seed register = {SEED1,SEED0}.
  - FIFO empty; level=0; out_valid=0; out_data=0.
  - FSM enters GEN_LO.
- Step function, all arithmetic mod 2^64:
  - result = s0+s1.
  - t = s0^s1.
  - s0' = rotl(s0,24) ^ t ^ (t<<16).
  - s1' = rotl(t,37).
- FSM, two run states plus one commit state:
  - GEN_LO: if level<DEPTH, push result[31:0], latch hi_hold=result[63:32], apply step, go to GEN_HI. Otherwise hold.
  - GEN_HI: if level<DEPTH, push hi_hold, go to GEN_LO. Otherwise hold.
  - COMMIT: one cycle. Load s0/s1 from the shadow register, flush the FIFO (level=0, out_valid=0), no push, go to GEN_LO.
- Full condition: push is gated on the registered level<DEPTH only. A pop in the same cycle does not create room that cycle.
- Pop: out_valid && out_ready removes the head word.
  - Simultaneous push and pop gives an unchanged level.
  - out_data changes only on a pop, or on a push into an empty FIFO.
- out_valid = (level != 0), from registered state only.
  - The first word is visible on the 2nd rising edge after reset deasserts: edge 1 pushes it, out_valid is high after that edge.
- Seeding:
  - seed_wr writes seed_data into the shadow word selected by seed_idx, in any state.
  - seed_wr with seed_idx=3 writes that word and then enters COMMIT on the next edge.
  - Writes to indices 0–2 do not disturb generation.
- Zero seed: if the committed shadow value is all-zero (a forbidden xoroshiro state), s0/s1 load SEED0/SEED1 instead.
- Flush vs pop: in the COMMIT cycle the flush wins. A simultaneous out_ready handshake is treated as consumed, and the word is discarded with the rest.
- Reset mid-operation, including mid-seed-sequence or in COMMIT, returns everything to the reset state and reloads the shadow register.
- Word order per 64-bit result: low half, then high half.
- Steady-state throughput: 1 word per cycle while not full.

Test Plan:
- Reset, out_ready=1 → words 32'h0000_0003, 32'h0000_0000, 32'h0103_0003, 32'h0000_0060 in order, one per cycle after the first.
- Reset, out_ready=0 for 20 cycles → level saturates at 4, out_valid=1, out_data=32'h3. Then raise out_ready → same 4-word sequence, with no word skipped or repeated.
- Seed writes idx0=5, idx1=0, idx2=32'hA, idx3=0, out_ready=1 → after COMMIT, out_valid=0 for one cycle, then 32'h0000_000F, 32'h0, 32'h050F_000F, 32'h0000_01E0.
- All-zero seed written (four writes of 0) → output restarts at 32'h3, 32'h0, 32'h0103_0003, 32'h0000_0060.
- Commit while the FIFO is full and out_ready=1 in the commit cycle → level drops to 0 and only new-seed words follow. Separately, reset asserted mid-stream → out_valid=0, level=0, and the sequence restarts at 32'h3.
- Random out_ready toggling over 10k cycles versus a reference model → exact word-sequence match, level never exceeds DEPTH, out_data stable while out_valid && !out_ready.
